// File: rtl/res_arb.sv
// res_arb: two-requester arbiter for the result memory.
// Requester 0 is the distance-transform engine and requester 1 is the host readout.
// A requester that raises rN_lock keeps ownership across back-to-back accesses.
// Optional feature macro: RES_ARB_RR_EN.
//   Defined:   contested IDLE cycles alternate between the requesters (round-robin).
//   Undefined: contested IDLE cycles always go to requester 0 (fixed priority).
module res_arb #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_wr,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_wr,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              res_rd,
    output logic              res_wr,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_do,
    input  logic [DATA_W-1:0] res_di
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_last;      // index of the most recently granted requester
    logic       r_rvalid0;
    logic       r_rvalid1;
    logic       w_win0;      // winner of a contested IDLE cycle is requester 0
    logic       w_gnt0;
    logic       w_gnt1;

`ifdef RES_ARB_RR_EN
    // Requester 0 wins a contest when requester 1 was the last one served.
    assign w_win0 = r_last;
`else
    // Requester 0 always wins; last-grant is still tracked but does not steer the pick.
    assign w_win0 = 1'b1 | r_last;
`endif

    // Combinational grant from the requests, ownership state and last-grant record.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r0_req && r1_req) begin
                    w_gnt0 = w_win0;
                    w_gnt1 = ~w_win0;
                end else begin
                    w_gnt0 = r0_req;
                    w_gnt1 = r1_req;
                end
            end
            S_OWN0:  w_gnt0 = r0_req;
            S_OWN1:  w_gnt1 = r1_req;
            default: begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        endcase
    end

    // Grants are forced low while reset is held so nothing reaches the memory.
    assign r0_gnt = w_gnt0 & reset;
    assign r1_gnt = w_gnt1 & reset;

    // Route the granted requester's access onto the memory port; idle port drives zeros.
    always_comb begin
        res_rd   = 1'b0;
        res_wr   = 1'b0;
        res_addr = '0;
        res_do   = '0;
        if (r0_gnt) begin
            res_rd   = ~r0_wr;
            res_wr   = r0_wr;
            res_addr = r0_addr;
            res_do   = r0_wdata;
        end else if (r1_gnt) begin
            res_rd   = ~r1_wr;
            res_wr   = r1_wr;
            res_addr = r1_addr;
            res_do   = r1_wdata;
        end
    end

    // Ownership follows the lock of the access just granted; no grant means release.
    always_comb begin
        w_state_next = S_IDLE;
        if (w_gnt0 && r0_lock) begin
            w_state_next = S_OWN0;
        end else if (w_gnt1 && r1_lock) begin
            w_state_next = S_OWN1;
        end
    end

    // State, last-grant and read-valid registers; reset drops ownership and pending reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rvalid0 <= w_gnt0 & ~r0_wr;
            r_rvalid1 <= w_gnt1 & ~r1_wr;
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
        end
    end

    assign r0_rvalid = r_rvalid0;
    assign r1_rvalid = r_rvalid1;
    assign r0_rdata  = r_rvalid0 ? res_di : '0;
    assign r1_rdata  = r_rvalid1 ? res_di : '0;

endmodule

// File: doc/res_arb.md
RES_ARB -- requirements
Module: res_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, result-memory address width (128x128 map).
REQ-002 The block SHALL have parameter DATA_W, default 8, result-memory data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 r0_req / r1_req  input  1  access request from requester 0 (distance-transform engine) / requester 1 (host readout).
REQ-006 r0_wr / r1_wr  input  1  1 = write, 0 = read; qualified by rN_req.
REQ-007 r0_lock / r1_lock  input  1  keep ownership after the current access.
REQ-008 r0_addr / r1_addr  input  ADDR_W  access address.
REQ-009 r0_wdata / r1_wdata  input  DATA_W  write data.
REQ-010 r0_gnt / r1_gnt  output  1  access accepted this cycle.
REQ-011 r0_rvalid / r1_rvalid  output  1  read data valid, one cycle after a granted read.
REQ-012 r0_rdata / r1_rdata  output  DATA_W  read data, equals res_di.
REQ-013 res_rd / res_wr  output  1  memory read/write strobe.
REQ-014 res_addr  output  ADDR_W, res_do  output  DATA_W  memory address / write data.
REQ-015 res_di  input  DATA_W  memory read data, valid the cycle after res_rd.

Function
REQ-016 States SHALL be IDLE, OWN0, OWN1, held in a state register.
REQ-017 At most one rN_gnt SHALL be high in any cycle; the grant is combinational from rN_req, state and last-grant register.
REQ-018 In OWN0 only requester 0 SHALL be granted (r1 waits); in OWN1 only requester 1.
REQ-019 In IDLE with one request, that requester SHALL be granted the same cycle.
REQ-020 In IDLE with both requests, the winner SHALL be per REQ-031/032.
REQ-021 In a granted cycle: res_addr = granted addr, res_wr = granted wr, res_rd = ~granted wr, res_do = granted wdata; ungranted cycle: res_rd = res_wr = 0, res_addr = 0, res_do = 0.
REQ-022 rN_rvalid SHALL be 1 exactly one cycle after a granted read of requester N; rN_rdata = res_di (0 when rvalid low).
REQ-023 Transition: grant to N with rN_lock=1 -> OWNN; grant with lock=0 -> IDLE.
REQ-024 In OWNN, rN_req=0 or rN_lock=0 at a grant SHALL release to IDLE at next edge; rN_req=0 releases without access.
REQ-025 Last-grant register SHALL record the index of every granted requester.
REQ-026 Back-to-back grants (one per cycle) SHALL be supported; no bubble between accesses of one owner.
REQ-027 Address/data SHALL pass through unmodified; no width conversion.

Reset
REQ-028 On reset low: state = IDLE, last-grant = 1, r0_rvalid = r1_rvalid = 0, all grants/strobes 0, all data outputs 0.
REQ-029 Reset mid-lock SHALL drop ownership immediately; an outstanding rvalid SHALL be cancelled.
REQ-030 After reset release the first contested IDLE cycle SHALL grant requester 0.

Configuration
REQ-031 With RES_ARB_RR_EN defined: contested IDLE grant SHALL go to the requester not recorded in last-grant (round-robin).
REQ-032 Without RES_ARB_RR_EN: contested IDLE grant SHALL always go to requester 0 (fixed priority); last-grant register still updated.

Verification
REQ-033 r0_req read addr 0x0081, r1 idle -> r0_gnt same cycle, res_rd=1 res_addr=0x0081; next cycle r0_rvalid=1, r0_rdata=res_di.
REQ-034 r0 lock held over 4 reads (0x0000,0x0001,0x0002,0x007F) while r1_req high -> four consecutive r0 grants, r1_gnt=0 throughout, r1 granted cycle after r0_lock drops.
REQ-035 Both requesting in IDLE, lock=0, RES_ARB_RR_EN defined -> grants alternate r0,r1,r0,r1; undefined -> r0 every cycle.
REQ-036 r1 write addr 0x3FFF data 0x7F -> res_wr=1, res_addr=0x3FFF, res_do=0x7F, no rvalid.
REQ-037 Assert reset during OWN1 with read outstanding -> state IDLE, r1_rvalid=0 next cycle; after release, contested request grants r0.
